// File: rtl/frame_pkg.sv
// Shared constants for the frame memory arbiter: FSM encoding and default frame geometry.
package frame_pkg;

    localparam int unsigned AddsWidthDef   = 18;
    localparam int unsigned HorzVisibleDef = 640;
    localparam int unsigned VertVisibleDef = 480;
    localparam int unsigned PixelWidth     = 10;

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StRecover = 1'b1;

endpackage

// File: rtl/pixel_addr_gen.sv
// Combinational bounds check and pixel-to-address mapping.
// FRAME_ARB_HALF_RES_EN selects the half-resolution (2x2 replicated) storage layout.
module pixel_addr_gen
    import frame_pkg::*;
#(
    parameter int unsigned ADDS_WIDTH   = AddsWidthDef,
    parameter int unsigned HORZ_VISIBLE = HorzVisibleDef,
    parameter int unsigned VERT_VISIBLE = VertVisibleDef
) (
    input  logic [PixelWidth-1:0] x_pixel_i,
    input  logic [PixelWidth-1:0] y_pixel_i,
    output logic [ADDS_WIDTH-1:0] addr_o,
    output logic                  in_bounds_o
);

    logic [ADDS_WIDTH-1:0] x_ext;
    logic [ADDS_WIDTH-1:0] y_ext;
    logic [ADDS_WIDTH-1:0] row_base;

    assign in_bounds_o = (32'(x_pixel_i) < HORZ_VISIBLE) && (32'(y_pixel_i) < VERT_VISIBLE);

`ifdef FRAME_ARB_HALF_RES_EN
    assign x_ext    = ADDS_WIDTH'(x_pixel_i >> 1);
    assign y_ext    = ADDS_WIDTH'(y_pixel_i >> 1);
    assign row_base = y_ext * ADDS_WIDTH'(HORZ_VISIBLE / 2);
`else
    assign x_ext    = ADDS_WIDTH'(x_pixel_i);
    assign y_ext    = ADDS_WIDTH'(y_pixel_i);
    assign row_base = y_ext * ADDS_WIDTH'(HORZ_VISIBLE);
`endif

    // Product is kept at address width on purpose: wraps, never saturates.
    assign addr_o = in_bounds_o ? (row_base + x_ext) : '0;

endmodule

// File: rtl/frame_mem_arbiter.sv
// Shares a single-port frame memory between the display fetch path (priority) and a
// loader write port. Address layout follows FRAME_ARB_HALF_RES_EN (see pixel_addr_gen).
module frame_mem_arbiter
    import frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDS_WIDTH   = AddsWidthDef,
    parameter int unsigned HORZ_VISIBLE = HorzVisibleDef,
    parameter int unsigned VERT_VISIBLE = VertVisibleDef,
    parameter int unsigned STARVE_LIMIT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PixelWidth-1:0] x_pixel_i,
    input  logic [PixelWidth-1:0] y_pixel_i,
    input  logic                  drawn_en_i,
    input  logic                  wr_req_i,
    input  logic [ADDS_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ack_o,
    output logic                  wr_starve_o,
    output logic [ADDS_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    output logic                  pix_valid_o
);

    localparam int unsigned         CntWidth = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(STARVE_LIMIT);

    logic [ADDS_WIDTH-1:0] disp_addr;
    logic                  disp_in_bounds;

    logic [0:0]            state_q, state_d;
    logic                  wr_grant;
    logic [ADDS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q;
    logic                  wr_ack_q;
    logic [CntWidth-1:0]   starve_cnt_q, starve_cnt_d;
    logic                  wr_starve_q;

    // Fetch tracking: stage 1 aligns with mem_addr, stage 2 with mem_rdata.
    logic                  fetch_v1_q, fetch_oob1_q;
    logic                  fetch_v2_q, fetch_oob2_q;
    logic [DATA_WIDTH-1:0] pix_data_q;
    logic                  pix_valid_q;

    pixel_addr_gen #(
        .ADDS_WIDTH   (ADDS_WIDTH),
        .HORZ_VISIBLE (HORZ_VISIBLE),
        .VERT_VISIBLE (VERT_VISIBLE)
    ) u_pixel_addr_gen (
        .x_pixel_i   (x_pixel_i),
        .y_pixel_i   (y_pixel_i),
        .addr_o      (disp_addr),
        .in_bounds_o (disp_in_bounds)
    );

    always_comb begin
        wr_grant     = ~drawn_en_i & (state_q == StIdle) & wr_req_i;
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            StIdle:    if (wr_grant) state_d = StRecover;
            default:   state_d = StIdle;
        endcase

        if (drawn_en_i) begin
            mem_addr_d = disp_addr;
        end else if (wr_grant) begin
            mem_addr_d  = wr_addr_i;
            mem_wdata_d = wr_data_i;
        end

        if (!wr_req_i || wr_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CntMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            starve_cnt_q <= '0;
            wr_starve_q  <= 1'b0;
            fetch_v1_q   <= 1'b0;
            fetch_oob1_q <= 1'b0;
            fetch_v2_q   <= 1'b0;
            fetch_oob2_q <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= wr_grant;
            wr_ack_q     <= wr_grant;
            starve_cnt_q <= starve_cnt_d;
            wr_starve_q  <= (starve_cnt_d == CntMax);
            fetch_v1_q   <= drawn_en_i;
            fetch_oob1_q <= ~disp_in_bounds;
            fetch_v2_q   <= fetch_v1_q;
            fetch_oob2_q <= fetch_oob1_q;
            pix_valid_q  <= fetch_v2_q;
            // pix_data holds its last fetched value between fetches.
            if (fetch_v2_q) begin
                pix_data_q <= fetch_oob2_q ? '0 : mem_rdata_i;
            end
        end
    end

    assign wr_ack_o    = wr_ack_q;
    assign wr_starve_o = wr_starve_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign pix_data_o  = pix_data_q;
    assign pix_valid_o = pix_valid_q;

endmodule
